// File: rtl/rd_scheduler.sv
// rd_scheduler: lamp phase sequencer and reward-sampling controller for the
// traffic-light accelerator. It accepts one action (the road to serve), runs the
// yellow / optional all-red / green phases, and latches the queue levels into
// the reward decider. It then returns the decider's reward on a valid/ready
// handshake.
// Optional feature macro: ALLRED_EN inserts an all-red phase on road changes.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   act_valid/act/act_ready    action handshake from the agent (act = road 0..3)
//   L0..L3                     live queue levels from the sensors
//   rd_L0..rd_L3, rd_R         latched levels to / registered reward from decider
//   reward/_valid/_ready       reward handshake back to the agent
//   light_road/_green/_yellow  lamp state (green=yellow=0 means all-red)
//   step_count                 completed reward handshakes, wraps at 2^16
module rd_scheduler #(
  parameter int L_WIDTH       = 4,
  parameter int R_WIDTH       = 16,
  parameter int GREEN_CYCLES  = 16,
  parameter int YELLOW_CYCLES = 4,
  parameter int ALLRED_CYCLES = 2,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      act_valid,
  input  logic [1:0]                act,
  output logic                      act_ready,
  input  logic [L_WIDTH-1:0]        L0,
  input  logic [L_WIDTH-1:0]        L1,
  input  logic [L_WIDTH-1:0]        L2,
  input  logic [L_WIDTH-1:0]        L3,
  output logic [L_WIDTH-1:0]        rd_L0,
  output logic [L_WIDTH-1:0]        rd_L1,
  output logic [L_WIDTH-1:0]        rd_L2,
  output logic [L_WIDTH-1:0]        rd_L3,
  input  logic signed [R_WIDTH-1:0] rd_R,
  output logic signed [R_WIDTH-1:0] reward,
  output logic                      reward_valid,
  input  logic                      reward_ready,
  output logic [1:0]                light_road,
  output logic                      light_green,
  output logic                      light_yellow,
  output logic [15:0]               step_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_YELLOW, S_ALLRED, S_GREEN, S_SAMPLE, S_SETTLE, S_CAPTURE, S_DONE
  } state_t;

  // Counter is loaded with N-1 on entry so the state lasts exactly N cycles.
  localparam logic [CNT_WIDTH-1:0] Y_LOAD = CNT_WIDTH'(YELLOW_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] A_LOAD = CNT_WIDTH'(ALLRED_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] G_LOAD = CNT_WIDTH'(GREEN_CYCLES - 1);

  state_t                    r_state;
  state_t                    w_next;
  logic [CNT_WIDTH-1:0]      r_cnt;
  logic [1:0]                r_next_road;
  logic [1:0]                r_light_road;
  logic                      r_light_green;
  logic [L_WIDTH-1:0]        r_rd_L0, r_rd_L1, r_rd_L2, r_rd_L3;
  logic signed [R_WIDTH-1:0] r_reward;
  logic [15:0]               r_step_count;

  logic                      w_load;
  logic [CNT_WIDTH-1:0]      w_load_val;
  logic                      w_cnt_zero;
  logic                      w_act_fire;
  logic                      w_reward_fire;
  logic                      w_to_yellow;
  logic                      w_to_green;
  logic [1:0]                w_green_road;

  assign act_ready     = (r_state == S_IDLE) && !rst;
  assign w_act_fire    = act_valid && act_ready;
  assign w_reward_fire = (r_state == S_DONE) && reward_ready;
  assign w_cnt_zero    = (r_cnt == '0);

  always_comb begin
    w_next       = r_state;
    w_load       = 1'b0;
    w_load_val   = '0;
    w_to_yellow  = 1'b0;
    w_to_green   = 1'b0;
    w_green_road = r_next_road;
    case (r_state)
      S_IDLE: begin
        if (w_act_fire) begin
          // Yellow clearance only when a different road currently has green;
          // the first action after reset finds all-red and goes straight to green.
          if (r_light_green && (act != r_light_road)) begin
            w_next      = S_YELLOW;
            w_load      = 1'b1;
            w_load_val  = Y_LOAD;
            w_to_yellow = 1'b1;
          end else begin
            w_next       = S_GREEN;
            w_load       = 1'b1;
            w_load_val   = G_LOAD;
            w_to_green   = 1'b1;
            w_green_road = act;  // next_road is being latched this same cycle
          end
        end
      end
      S_YELLOW: begin
        if (w_cnt_zero) begin
`ifdef ALLRED_EN
          w_next     = S_ALLRED;
          w_load     = 1'b1;
          w_load_val = A_LOAD;
`else
          w_next     = S_GREEN;
          w_load     = 1'b1;
          w_load_val = G_LOAD;
          w_to_green = 1'b1;
`endif
        end
      end
      S_ALLRED: begin
        if (w_cnt_zero) begin
          w_next     = S_GREEN;
          w_load     = 1'b1;
          w_load_val = G_LOAD;
          w_to_green = 1'b1;
        end
      end
      S_GREEN:   if (w_cnt_zero) w_next = S_SAMPLE;
      S_SAMPLE:  w_next = S_SETTLE;
      S_SETTLE:  w_next = S_CAPTURE;  // decider registers rd_R this cycle
      S_CAPTURE: w_next = S_DONE;
      S_DONE:    if (reward_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_next_road   <= 2'd0;
      r_light_road  <= 2'd0;
      r_light_green <= 1'b0;
      r_rd_L0       <= '0;
      r_rd_L1       <= '0;
      r_rd_L2       <= '0;
      r_rd_L3       <= '0;
      r_reward      <= '0;
      r_step_count  <= 16'd0;
    end else begin
      r_state <= w_next;
      if (w_load)
        r_cnt <= w_load_val;
      else if (!w_cnt_zero)
        r_cnt <= r_cnt - 1'b1;
      if (w_act_fire)
        r_next_road <= act;
      if (w_to_yellow)
        r_light_green <= 1'b0;
      if (w_to_green) begin
        r_light_green <= 1'b1;
        r_light_road  <= w_green_road;
      end
      if (r_state == S_SAMPLE) begin
        r_rd_L0 <= L0;
        r_rd_L1 <= L1;
        r_rd_L2 <= L2;
        r_rd_L3 <= L3;
      end
      if (r_state == S_CAPTURE)
        r_reward <= rd_R;
      if (w_reward_fire)
        r_step_count <= r_step_count + 16'd1;
    end
  end

  assign rd_L0        = r_rd_L0;
  assign rd_L1        = r_rd_L1;
  assign rd_L2        = r_rd_L2;
  assign rd_L3        = r_rd_L3;
  assign reward       = r_reward;
  assign reward_valid = (r_state == S_DONE);
  assign light_road   = r_light_road;
  assign light_green  = r_light_green;
  assign light_yellow = (r_state == S_YELLOW);
  assign step_count   = r_step_count;

endmodule

// File: doc/rd_scheduler.md
# rd_scheduler

Phase sequencer and reward-sampling controller for the traffic-light accelerator. It accepts one action (the road to serve) from the Q-learning agent, drives the lamp phase sequence (yellow clearance, optional all-red, green dwell), and latches the four queue levels into the reward decider. It then returns the decider's registered reward to the agent over a valid/ready handshake. It sits between the agent FSM, the road-level sensors and the reward decider.

## Interface
- L_WIDTH, 4: queue-level width per road; top two bits select the reward band in the decider
- R_WIDTH, 16: reward width, signed fixed point (16 or 32)
- GREEN_CYCLES, 16: green dwell, ≥1
- YELLOW_CYCLES, 4: yellow clearance, ≥1
- ALLRED_CYCLES, 2: all-red clearance (used only with ALLRED_EN), ≥1
- CNT_WIDTH, 8: phase counter width; every *_CYCLES value must be < 2^CNT_WIDTH
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- act_valid  in  1  agent presents an action
- act  in  2  road index 0..3 to serve
- act_ready  out  1  high only in IDLE and with rst low
- L0..L3  in  L_WIDTH each  live queue levels from the sensors
- rd_L0..rd_L3  out  L_WIDTH each  latched levels to the decider
- rd_R  in  R_WIDTH signed  decider output; registered, 1-cycle latency
- reward  out  R_WIDTH signed  captured reward
- reward_valid  out  1  reward available
- reward_ready  in  1  agent consumes the reward
- light_road  out  2  road the lamp phase applies to
- light_green, light_yellow  out  1 each  lamp state; both low means all-red
- step_count  out  16  completed reward handshakes; wraps at 2^16

## Operation
- States: IDLE, YELLOW, ALLRED, GREEN, SAMPLE, SETTLE, CAPTURE, DONE.
- IDLE: act_ready=1. On act_valid&act_ready, latch act into next_road.
  - Go to YELLOW if light_green=1 and act≠light_road.
  - Otherwise go to GREEN. This covers the same road and the first action after reset, when no road is green.
- YELLOW: light_yellow=1, light_green=0, light_road unchanged. Lasts YELLOW_CYCLES, then goes to ALLRED (macro) or GREEN.
- ALLRED: both lamps low. Lasts ALLRED_CYCLES, then GREEN.
- GREEN: on entry, light_road=next_road, light_green=1. Lasts GREEN_CYCLES, then SAMPLE.
- Green stays asserted through SAMPLE, SETTLE, CAPTURE, DONE and IDLE, until the next road change.
- SAMPLE: rd_Lx<=Lx at the end of the cycle.
- SETTLE: the decider registers rd_R.
- CAPTURE: reward<=rd_R.
- DONE: reward_valid=1, with reward held stable until reward_ready. On the handshake cycle, step_count increments and the state moves to IDLE.
- One phase down-counter (CNT_WIDTH) is loaded on each timed-state entry.
- act and the L inputs are ignored outside their sampling points.
- Reward is passed through unmodified; there is no arithmetic on it.

## Timing
- Reset values:
  - state IDLE
  - light_road=0, light_green=0, light_yellow=0 (all-red)
  - rd_L0..rd_L3=0, reward=0, reward_valid=0, step_count=0
  - act_ready=0 while rst is high
- Cycle 0 is the action-handshake cycle. Let Y=YELLOW_CYCLES, G=GREEN_CYCLES, A=ALLRED_CYCLES.
- Road change: yellow in cycles 1..Y, green from Y+1, SAMPLE at Y+G+1, reward_valid first high at Y+G+4.
- Same road or first action: green from 1, SAMPLE at G+1, reward_valid at G+4.
- ALLRED_EN adds A cycles on road changes only.
- Handshake in cycle n means act_ready is high in cycle n+1. The minimum action-to-action spacing is G+5 (same road).
- If reward_ready is already high on DONE entry, the handshake completes in that first DONE cycle.
- rst mid-sequence: returns to the reset state on the next edge. The in-flight reward is discarded and step_count is cleared.

## Configuration
- ALLRED_EN defined: ALLRED state inserted between YELLOW and GREEN on every road change.
- ALLRED_EN undefined: YELLOW goes directly to GREEN. The ALLRED state and the ALLRED_CYCLES parameter are unused.

## Test plan
- Reset, then act=2 in cycle 0, L={4'h0,4'h4,4'h8,4'hC}, defaults → light_green=1 and light_road=2 from cycle 1; rd_L latched in cycle 17; reward_valid in cycle 20 with reward equal to the decider output (0x6400+0+0x9C00+0x8000 wrapped to 16 bits).
- Green on road 2, then act=1 → yellow on road 2 for cycles 1–4, green on road 1 from cycle 5, reward_valid at cycle 24.
- Green on road 1, then act=1 → no yellow; reward_valid at cycle 20.
- reward_ready held low for 10 cycles in DONE → reward stable, reward_valid held, act_ready=0, step_count increments only on the handshake.
- rst pulsed in YELLOW → next cycle: all-red, IDLE, act_ready=1, reward_valid=0, step_count=0.
- ALLRED_EN defined with A=2 and a road change → both lamps low in cycles 5–6, green from cycle 7, reward_valid at cycle 26.
